// File: rtl/csa_resolver.sv
// Chunked carry-propagate resolver for a sum/carry pair, CHUNK bits per cycle.
// Optional out_zero flag under `define CSA_RESOLVER_ZERO_FLAG_EN.
module csa_resolver #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic             out_cout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] car_q, car_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic [CHUNK:0]   add;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
  logic             zacc_q, zacc_d;
  logic             zero_q, zero_d;
`endif

  // Operands shift down so the active chunk always sits in the low bits.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    car_d     = car_q;
    res_d     = res_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add = {1'b0, sum_q[CHUNK-1:0]}
        + {1'b0, car_q[CHUNK-1:0]}
        + (CHUNK+1)'(carry_q);
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    zacc_d = zacc_q;
    zero_d = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sum_d   = in_sum;
          car_d   = in_carry;
          carry_d = 1'b0;
          k_d     = '0;
          state_d = RUN;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
          zacc_d  = 1'b1;
`endif
        end
      end
      RUN: begin
        res_d[int'(k_q)*CHUNK +: CHUNK] = add[CHUNK-1:0];
        carry_d = add[CHUNK];
        sum_d   = sum_q >> CHUNK;
        car_d   = car_q >> CHUNK;
        k_d     = k_q + KW'(1);
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
        zacc_d  = zacc_q & (add[CHUNK-1:0] == '0);
`endif
        if (k_q == KW'(N-1)) begin
          cout_d  = add[CHUNK];
          k_d     = '0;
          state_d = DONE;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
          zero_d  = zacc_d;
`endif
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
          zero_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      car_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      car_q   <= car_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign out_result = res_q;
  assign out_cout   = cout_q;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
  assign out_zero   = zero_q;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Directed-vector and random testbench for csa_resolver (WIDTH=32, CHUNK=8).
// Build with CSA_RESOLVER_ZERO_FLAG_EN defined to cover out_zero.
module tb_csa_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic [31:0] in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cout;
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_resolver #(.WIDTH(32), .CHUNK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    .out_zero   (out_zero),
`endif
    .out_cout   (out_cout)
  );

  typedef struct {
    logic [31:0] s;
    logic [31:0] c;
    logic [31:0] r;
    logic        co;
  } vec_t;

  vec_t tv[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // One operation with out_ready=1; checks latency, result and release.
  task automatic do_op(input string nm, input logic [31:0] s,
                       input logic [31:0] c, input logic [31:0] r,
                       input logic co);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    in_sum    = s;
    in_carry  = c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd4);
    chk({nm, "_res"}, 64'(out_result), 64'(r));
    chk({nm, "_cout"}, 64'(out_cout), 64'(co));
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    chk({nm, "_zero"}, 64'(out_zero), 64'(r == 32'd0));
`endif
    tick();
    chk({nm, "_vld_drop"}, 64'({out_valid, in_ready}), 64'b01);
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    chk({nm, "_zero_clr"}, 64'(out_zero), 64'd0);
`endif
  endtask

  logic [32:0] q[$];
  logic [32:0] e;
  logic [32:0] got;
  int          sent;
  int          rcvd;
  int          cyc;
  int          w;
  bit          fire_in;
  bit          fire_out;
  bit          in_flight;
  bit          stayed_low;

  initial begin
    tv[0] = '{32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
    tv[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    tv[2] = '{32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
    tv[3] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};
    tv[4] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    tv[5] = '{32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0};
    tv[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
    tv[7] = '{32'h00000001, 32'h00000000, 32'h00000001, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_cout", 64'(out_cout), 64'd0);
`ifdef CSA_RESOLVER_ZERO_FLAG_EN
    chk("rst_zero", 64'(out_zero), 64'd0);
`endif

    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), tv[i].s, tv[i].c, tv[i].r, tv[i].co);

    // Backpressure with an ignored in_valid pulse while DONE.
    out_ready = 1'b0;
    in_sum    = 32'h12345678;
    in_carry  = 32'h11111111;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    chk("bp_lat", 64'(w), 64'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_sum   = 32'hFFFFFFFF;
        in_carry = 32'h00000001;
        in_valid = 1'b1;
      end
      chk($sformatf("bp_hold%0d", i),
          {out_valid, in_ready, out_cout, 29'd0, out_result},
          {1'b1, 1'b0, 1'b0, 29'd0, 32'h23456789});
      tick();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    chk("bp_valid_before", 64'(out_valid), 64'd1);
    tick();
    chk("bp_release", 64'({out_valid, in_ready}), 64'b01);
    stayed_low = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || !in_ready) stayed_low = 1'b0;
    end
    chk("bp_pulse_ignored", 64'(stayed_low), 64'd1);

    // Reset on the second RUN cycle, with in_valid also high.
    in_sum   = 32'hAAAAAAAA;
    in_carry = 32'h55555555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("abort_state",
        {out_valid, in_ready, out_cout, 29'd0, out_result},
        {1'b0, 1'b1, 1'b0, 29'd0, 32'd0});
    do_op("after_abort", 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0);

    // Random traffic against a queued golden model.
    sent      = 0;
    rcvd      = 0;
    cyc       = 0;
    in_flight = 1'b0;
    in_valid  = 1'b0;
    while (rcvd < 1000 && cyc < 40000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_sum   = $urandom;
        in_carry = $urandom;
        if ($urandom_range(0, 7) == 0) in_carry = ~in_sum + 32'd1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_ready == in_flight) begin
        errors++;
        $display("FAIL rnd_in_ready got=%0d want=%0d cyc=%0d",
                 in_ready, !in_flight, cyc);
      end
      checks++;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_in) begin
        e = {1'b0, in_sum} + {1'b0, in_carry};
        q.push_back(e);
        sent++;
      end
      if (fire_out) begin
        got = {out_cout, out_result};
        if (q.size() == 0) begin
          chk("rnd_unexpected", 64'(got), 64'h1_0000_0000_0000);
        end else begin
          e = q.pop_front();
          chk($sformatf("rnd%0d", rcvd), 64'(got), 64'(e));
        end
        rcvd++;
      end
      tick();
      if (fire_in) begin
        in_valid  = 1'b0;
        in_flight = 1'b1;
      end
      if (fire_out) in_flight = 1'b0;
      cyc++;
    end
    chk("rnd_count", 64'(rcvd), 64'd1000);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
